// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared types and constants for the decode stage.
//   - fetch bundle geometry (addr/block/inst typedefs shared with fetch)
//   - opcode enum, HALT word, instruction field slice positions
//   - dec_t: the registered decoded bundle handed to execute
//   - op_ctl(): per-opcode control (legality, source usage, write, halt)
package decode_stage_pkg;

  localparam int ADDR_W  = 9;
  localparam int BLOCK_W = 16;
  localparam int NREG    = 16;
  localparam int REG_W   = 4;
  localparam int IMM_W   = 8;
  localparam int INST_W  = ADDR_W + BLOCK_W;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [INST_W-1:0]  inst_t;
  typedef logic [REG_W-1:0]   reg_t;
  typedef logic [IMM_W-1:0]   imm_t;

  // Field slices inside the instruction word
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam block_t HALT_WORD = 16'hFFFF;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_LI   = 4'h5,
    OP_LD   = 4'h8,
    OP_ST   = 4'h9,
    OP_BEQZ = 4'hA,
    OP_JMP  = 4'hB,
    OP_HALT = 4'hF
  } opcode_e;

  typedef struct packed {
    logic    valid;
    addr_t   pc;
    opcode_e op;
    reg_t    rd;
    reg_t    rs;
    reg_t    rt;
    imm_t    imm;
    logic    wr;
    logic    illegal;
  } dec_t;

  // Decoded control for one instruction word
  typedef struct packed {
    logic legal;
    logic use_rs;
    logic use_rt;
    logic use_rd;   // BEQZ tests rd, so rd is a source there
    logic wr;
    logic halt;
  } ctl_t;

  function automatic ctl_t op_ctl(input block_t word);
    ctl_t c;
    c = '0;
    case (opcode_e'(word[OP_MSB:OP_LSB]))
      OP_NOP: c.legal = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        c.legal  = 1'b1;
        c.use_rs = 1'b1;
        c.use_rt = 1'b1;
        c.wr     = 1'b1;
      end
      OP_LI: begin
        c.legal = 1'b1;
        c.wr    = 1'b1;
      end
      OP_LD: begin
        c.legal  = 1'b1;
        c.use_rs = 1'b1;
        c.wr     = 1'b1;
      end
      OP_ST: begin
        c.legal  = 1'b1;
        c.use_rs = 1'b1;
        c.use_rt = 1'b1;
      end
      OP_BEQZ: begin
        c.legal  = 1'b1;
        c.use_rd = 1'b1;
      end
      OP_JMP: c.legal = 1'b1;
      OP_HALT: begin
        // Only the all-ones word is HALT; the rest of the 0xF page is illegal
        if (word == HALT_WORD) begin
          c.legal = 1'b1;
          c.halt  = 1'b1;
        end else begin
          c = '0;
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: register-pending bits for RAW hazard detection.
//   clk, rst         clock, async active-low reset
//   set_en/set_reg   mark a register pending on issue of a writer
//   clr_en/clr_reg   writeback retires a pending register
//   qa_*/qb_*        two source-register queries
//   hazard           a queried register is pending after this cycle's clear
//   pending          current pending vector (before this cycle's update)
// r0 is never marked pending and a clear of r0 is ignored.
module decode_scoreboard
  import decode_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  reg_t            set_reg,
  input  logic            clr_en,
  input  reg_t            clr_reg,
  input  logic            qa_en,
  input  reg_t            qa_reg,
  input  logic            qb_en,
  input  reg_t            qb_reg,
  output logic            hazard,
  output logic [NREG-1:0] pending
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] clr_mask_s;
  logic [NREG-1:0] after_clr_s;
  logic            hit_a_s;
  logic            hit_b_s;

  // Set/clear masks, clear-bypassed view for the query, next pending state
  always_comb begin
    set_mask_s = '0;
    clr_mask_s = '0;
    if (set_en && (set_reg != 4'd0)) begin
      set_mask_s[set_reg] = 1'b1;
    end else begin
      set_mask_s = '0;
    end
    if (clr_en && (clr_reg != 4'd0)) begin
      clr_mask_s[clr_reg] = 1'b1;
    end else begin
      clr_mask_s = '0;
    end
    // Writeback clear is visible to this cycle's hazard check
    after_clr_s = pending_q & ~clr_mask_s;
    // Set is applied after clear so a same-cycle set of the same reg wins
    pending_d   = after_clr_s | set_mask_s;
    hit_a_s     = qa_en && (qa_reg != 4'd0) && after_clr_s[qa_reg];
    hit_b_s     = qb_en && (qb_reg != 4'd0) && after_clr_s[qb_reg];
    hazard      = hit_a_s | hit_b_s;
  end

  // Pending-bit storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode with RAW scoreboard, flush and sticky HALT.
//   clk, rst              clock, async active-low reset
//   inst_in               fetch bundle {pc[24:16], instruction[15:0]}
//   do_branch, do_jump    flush requests from downstream
//   wb_en, wb_reg         writeback retiring a pending register
//   stall                 combinational hold request to fetch
//   dec_*                 registered decoded bundle (1-cycle latency)
//   halted                sticky halt, cleared only by reset
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [24:0] inst_in,
  input  logic        do_branch,
  input  logic        do_jump,
  input  logic        wb_en,
  input  logic [3:0]  wb_reg,
  output logic        stall,
  output logic        dec_valid,
  output logic [8:0]  dec_pc,
  output logic [3:0]  dec_op,
  output logic [3:0]  dec_rd,
  output logic [3:0]  dec_rs,
  output logic [3:0]  dec_rt,
  output logic [7:0]  dec_imm,
  output logic        dec_wr,
  output logic        dec_illegal,
  output logic        halted
);

  dec_t            dec_q;
  dec_t            dec_d;
  logic            halted_q;
  logic            halted_d;

  block_t          word_s;
  addr_t           pc_s;
  ctl_t            ctl_s;
  reg_t            rd_s;
  reg_t            rs_s;
  reg_t            rt_s;
  logic            qa_en_s;
  reg_t            qa_reg_s;
  logic            flush_s;
  logic            hazard_s;
  logic            stall_s;
  logic            set_en_s;
  logic [NREG-1:0] pending_s;

  // Field extraction and source-register selection for the hazard query
  always_comb begin
    word_s = inst_in[BLOCK_W-1:0];
    pc_s   = inst_in[INST_W-1:BLOCK_W];
    ctl_s  = op_ctl(word_s);
    rd_s   = word_s[RD_MSB:RD_LSB];
    rs_s   = word_s[RS_MSB:RS_LSB];
    rt_s   = word_s[RT_MSB:RT_LSB];
    // Port A carries rs, or rd for BEQZ; no opcode uses both
    if (ctl_s.use_rd) begin
      qa_en_s  = 1'b1;
      qa_reg_s = rd_s;
    end else begin
      qa_en_s  = ctl_s.use_rs;
      qa_reg_s = rs_s;
    end
  end

  decode_scoreboard u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (set_en_s),
    .set_reg (rd_s),
    .clr_en  (wb_en),
    .clr_reg (wb_reg),
    .qa_en   (qa_en_s),
    .qa_reg  (qa_reg_s),
    .qb_en   (ctl_s.use_rt),
    .qb_reg  (rt_s),
    .hazard  (hazard_s),
    .pending (pending_s)
  );

  // Stall request; a hazard needs at least one pending entry
  always_comb begin
    flush_s = do_branch | do_jump;
    stall_s = hazard_s & (|pending_s) & ~flush_s & ~halted_q;
  end

  // Next decoded bundle, halt flag and scoreboard set, in priority order
  always_comb begin
    dec_d    = '0;
    halted_d = halted_q;
    set_en_s = 1'b0;
    if (flush_s) begin
      dec_d = '0;
    end else if (halted_q) begin
      dec_d = '0;
    end else if (stall_s) begin
      dec_d = '0;
    end else begin
      dec_d.pc      = pc_s;
      dec_d.op      = opcode_e'(word_s[OP_MSB:OP_LSB]);
      dec_d.rd      = rd_s;
      dec_d.rs      = rs_s;
      dec_d.rt      = rt_s;
      dec_d.imm     = word_s[IMM_MSB:IMM_LSB];
      dec_d.wr      = ctl_s.wr;
      dec_d.illegal = ~ctl_s.legal;
      // NOP, HALT and illegal words go downstream as bubbles
      dec_d.valid   = ctl_s.legal & ~ctl_s.halt &
                      (word_s[OP_MSB:OP_LSB] != 4'h0);
      halted_d      = halted_q | ctl_s.halt;
      set_en_s      = dec_d.valid & ctl_s.wr;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      dec_q    <= dec_d;
      halted_q <= halted_d;
    end
  end

  assign stall       = stall_s;
  assign dec_valid   = dec_q.valid;
  assign dec_pc      = dec_q.pc;
  assign dec_op      = dec_q.op;
  assign dec_rd      = dec_q.rd;
  assign dec_rs      = dec_q.rs;
  assign dec_rt      = dec_q.rt;
  assign dec_imm     = dec_q.imm;
  assign dec_wr      = dec_q.wr;
  assign dec_illegal = dec_q.illegal;
  assign halted      = halted_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors for decode_stage with hand-computed
// expectations. Inputs change 1ns after each rising edge; combinational
// stall is checked 1ns after that, registered outputs after the next edge.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [24:0] inst_in;
  logic        do_branch;
  logic        do_jump;
  logic        wb_en;
  logic [3:0]  wb_reg;
  logic        stall;
  logic        dec_valid;
  logic [8:0]  dec_pc;
  logic [3:0]  dec_op;
  logic [3:0]  dec_rd;
  logic [3:0]  dec_rs;
  logic [3:0]  dec_rt;
  logic [7:0]  dec_imm;
  logic        dec_wr;
  logic        dec_illegal;
  logic        halted;

  int n_vec = 0;
  int n_bad = 0;

  decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .inst_in     (inst_in),
    .do_branch   (do_branch),
    .do_jump     (do_jump),
    .wb_en       (wb_en),
    .wb_reg      (wb_reg),
    .stall       (stall),
    .dec_valid   (dec_valid),
    .dec_pc      (dec_pc),
    .dec_op      (dec_op),
    .dec_rd      (dec_rd),
    .dec_rs      (dec_rs),
    .dec_rt      (dec_rt),
    .dec_imm     (dec_imm),
    .dec_wr      (dec_wr),
    .dec_illegal (dec_illegal),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [8:0] pc, input logic [15:0] w);
    inst_in = {pc, w};
    #1;
  endtask

  initial begin
    rst = 1'b0; inst_in = 25'd0; do_branch = 1'b0; do_jump = 1'b0;
    wb_en = 1'b0; wb_reg = 4'd0;
    #12;
    chk("rst_valid",   {31'd0, dec_valid},   32'd0);
    chk("rst_halted",  {31'd0, halted},      32'd0);
    chk("rst_stall",   {31'd0, stall},       32'd0);
    chk("rst_illegal", {31'd0, dec_illegal}, 32'd0);
    tick();
    rst = 1'b1;

    // LI r1,0x18 -> r1 pending
    drive(9'd1, 16'h5118);
    chk("li_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("li_valid", {31'd0, dec_valid}, 32'd1);
    chk("li_pc",    {23'd0, dec_pc},    32'd1);
    chk("li_op",    {28'd0, dec_op},    32'd5);
    chk("li_rd",    {28'd0, dec_rd},    32'd1);
    chk("li_imm",   {24'd0, dec_imm},   32'h18);
    chk("li_wr",    {31'd0, dec_wr},    32'd1);

    // ADD r3,r1,r2 stalls on r1 until writeback of r1 bypasses
    drive(9'd2, 16'h1312);
    chk("raw_stall0", {31'd0, stall}, 32'd1);
    tick();
    chk("raw_bubble", {31'd0, dec_valid}, 32'd0);
    chk("raw_stall1", {31'd0, stall},     32'd1);
    wb_en = 1'b1; wb_reg = 4'd1; #1;
    chk("wb_bypass", {31'd0, stall}, 32'd0);
    tick();
    wb_en = 1'b0;
    chk("add_valid", {31'd0, dec_valid}, 32'd1);
    chk("add_op",    {28'd0, dec_op},    32'd1);
    chk("add_rd",    {28'd0, dec_rd},    32'd3);
    chk("add_rs",    {28'd0, dec_rs},    32'd1);
    chk("add_rt",    {28'd0, dec_rt},    32'd2);

    // ADD r4,r3,r1: r3 pending; branch flush overrides stall
    drive(9'd3, 16'h1431);
    chk("r3_stall", {31'd0, stall}, 32'd1);
    do_branch = 1'b1; #1;
    chk("br_stall", {31'd0, stall}, 32'd0);
    tick();
    do_branch = 1'b0; #1;
    chk("br_valid",   {31'd0, dec_valid}, 32'd0);
    chk("br_sb_kept", {31'd0, stall},     32'd1);

    // LI r2,7 issues normally after the flush
    drive(9'd4, 16'h5207);
    chk("li2_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("li2_valid", {31'd0, dec_valid}, 32'd1);
    chk("li2_rd",    {28'd0, dec_rd},    32'd2);
    chk("li2_pc",    {23'd0, dec_pc},    32'd4);

    // LI r4 killed by jump flush must not mark r4 pending
    do_jump = 1'b1;
    drive(9'd5, 16'h5405);
    tick();
    do_jump = 1'b0;
    chk("jmp_valid", {31'd0, dec_valid}, 32'd0);
    drive(9'd6, 16'h1540);
    chk("jmp_no_set", {31'd0, stall}, 32'd0);
    tick();
    chk("add5_valid", {31'd0, dec_valid}, 32'd1);

    // NOP and illegal words
    drive(9'd7, 16'h0000);
    tick();
    chk("nop_valid",   {31'd0, dec_valid},   32'd0);
    chk("nop_illegal", {31'd0, dec_illegal}, 32'd0);
    drive(9'd8, 16'h7123);
    tick();
    chk("ill7_flag",  {31'd0, dec_illegal}, 32'd1);
    chk("ill7_valid", {31'd0, dec_valid},   32'd0);
    drive(9'd9, 16'h0000);
    tick();
    chk("ill_oneshot", {31'd0, dec_illegal}, 32'd0);
    drive(9'd10, 16'hF000);
    tick();
    chk("illF_flag", {31'd0, dec_illegal}, 32'd1);

    // Same-cycle issue of LI r2 and writeback of r2: set wins
    wb_en = 1'b1; wb_reg = 4'd2;
    drive(9'd11, 16'h5299);
    tick();
    wb_en = 1'b0;
    chk("setwin_valid", {31'd0, dec_valid}, 32'd1);
    drive(9'd12, 16'h9020);
    chk("setwin_stall", {31'd0, stall}, 32'd1);
    wb_en = 1'b1; wb_reg = 4'd2; #1;
    chk("st_bypass", {31'd0, stall}, 32'd0);
    tick();
    wb_en = 1'b0;
    chk("st_valid", {31'd0, dec_valid}, 32'd1);
    chk("st_wr",    {31'd0, dec_wr},    32'd0);

    // BEQZ r3 sources rd
    drive(9'd13, 16'hA300);
    chk("beqz_stall", {31'd0, stall}, 32'd1);
    wb_en = 1'b1; wb_reg = 4'd3; #1;
    chk("beqz_bypass", {31'd0, stall}, 32'd0);
    tick();
    wb_en = 1'b0;
    chk("beqz_valid", {31'd0, dec_valid}, 32'd1);
    chk("beqz_op",    {28'd0, dec_op},    32'hA);

    // LI r0 never marks r0 pending
    drive(9'd14, 16'h5005);
    tick();
    chk("li0_valid", {31'd0, dec_valid}, 32'd1);
    chk("li0_rd",    {28'd0, dec_rd},    32'd0);
    drive(9'd15, 16'h1100);
    chk("r0_no_haz", {31'd0, stall}, 32'd0);
    tick();
    chk("add_r0_valid", {31'd0, dec_valid}, 32'd1);

    // HALT is sticky; later work is bubbled and stall is suppressed
    drive(9'd16, 16'hFFFF);
    tick();
    chk("halt_flag",  {31'd0, halted},    32'd1);
    chk("halt_valid", {31'd0, dec_valid}, 32'd0);
    drive(9'd17, 16'h5601);
    tick();
    chk("halt_li_valid", {31'd0, dec_valid}, 32'd0);
    chk("halt_sticky",   {31'd0, halted},    32'd1);
    drive(9'd18, 16'h1715);
    chk("halt_nostall", {31'd0, stall}, 32'd0);
    rst = 1'b0; #1;
    chk("halt_rst", {31'd0, halted}, 32'd0);
    rst = 1'b1;

    // Reset in the middle of a stall
    drive(9'd19, 16'h5601);
    tick();
    chk("li6_valid", {31'd0, dec_valid}, 32'd1);
    drive(9'd20, 16'h1760);
    chk("li6_stall", {31'd0, stall}, 32'd1);
    rst = 1'b0; #1;
    chk("mid_rst_stall", {31'd0, stall},     32'd0);
    chk("mid_rst_valid", {31'd0, dec_valid}, 32'd0);
    rst = 1'b1; #1;
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("post_rst_valid", {31'd0, dec_valid}, 32'd1);
    chk("post_rst_rd",    {28'd0, dec_rd},    32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
